wb_mst_bridge: RTL and testbench

//  Localbus-to-Wishbone master: turns single-cycle localbus wr/rd strobes into Wishbone classic

---
 rtl/wb_mst_bridge_if.sv | 23 ++
 rtl/wb_mst_bridge.sv | 143 ++++++++++++++
 tb/tb_wb_mst_bridge.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_mst_bridge_if.sv
// Wishbone classic bus bundle between the localbus bridge and a slave.
// Signal names keep the master-side _o/_i suffixes.
interface wb_mst_bridge_if;
    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [31:0] adr_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        ack_i;
    logic        err_i;

    modport master (
        output cyc_o, stb_o, we_o, adr_o, sel_o, dat_o,
        input  dat_i, ack_i, err_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, adr_o, sel_o, dat_o,
        output dat_i, ack_i, err_i
    );
endinterface

// File: rtl/wb_mst_bridge.sv
// Localbus strobe to Wishbone classic single-cycle master.
// One outstanding transfer, completion reported with a done pulse.
module wb_mst_bridge #(
    parameter int          TIMEOUT_CYC = 255,
    parameter logic [31:0] ADDR_BASE   = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        wr_in,
    input  logic        rd_in,
    input  logic [7:0]  addr_in,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        busy,
    output logic        done,
    output logic        err_out,
    output logic        drop_out,
    wb_mst_bridge_if.master wb
);
    localparam int CW = (TIMEOUT_CYC > 0) ?
                        $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYC);

    typedef enum logic {IDLE, BUS} state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [31:0] adr_q, adr_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] rdat_q, rdat_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        drop_q, drop_d;

    logic strobe;
    logic tmo;
    logic fin;

    assign strobe = wr_in | rd_in;
    assign tmo    = (TIMEOUT_CYC != 0) && (cnt_q == TMO);
    assign fin    = wb.ack_i | wb.err_i | tmo;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            sel_q   <= '0;
            dat_q   <= '0;
            rdat_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            rdat_q  <= rdat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (strobe) state_d = BUS;
            BUS:  if (fin)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        cyc_d  = cyc_q;
        we_d   = we_q;
        adr_d  = adr_q;
        sel_d  = sel_q;
        dat_d  = dat_q;
        rdat_d = rdat_q;
        busy_d = busy_q;
        done_d = 1'b0;
        err_d  = 1'b0;
        drop_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (strobe) begin
                    cnt_d  = '0;
                    cyc_d  = 1'b1;
                    we_d   = wr_in;
                    adr_d  = ADDR_BASE | {24'b0, addr_in};
                    sel_d  = 4'hF;
                    dat_d  = wr_in ? data_in : 32'h0;
                    busy_d = 1'b1;
                end
            end
            BUS: begin
                drop_d = strobe;
                if (fin) begin
                    cyc_d  = 1'b0;
                    we_d   = 1'b0;
                    adr_d  = '0;
                    sel_d  = '0;
                    dat_d  = '0;
                    busy_d = 1'b0;
                    done_d = 1'b0 | 1'b1;
                    // ack wins over a coincident timeout; err wins over ack
                    err_d  = wb.err_i | (tmo & ~wb.ack_i);
                    if (wb.ack_i && !wb.err_i && !we_q)
                        rdat_d = wb.dat_i;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: ;
        endcase
    end

    assign wb.cyc_o = cyc_q;
    assign wb.stb_o = cyc_q;
    assign wb.we_o  = we_q;
    assign wb.adr_o = adr_q;
    assign wb.sel_o = sel_q;
    assign wb.dat_o = dat_q;
    assign data_out = rdat_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err_out  = err_q;
    assign drop_out = drop_q;
endmodule

// File: tb/tb_wb_mst_bridge.sv
// Directed table-driven bench for wb_mst_bridge.
// Hand sequences cover drop, back-to-back and async reset.
module tb_wb_mst_bridge;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        wr_in = 1'b0;
    logic        rd_in = 1'b0;
    logic [7:0]  addr_in = '0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        busy, done, err_out, drop_out;

    int pass_cnt = 0;
    int total = 0;

    wb_mst_bridge_if wb ();

    wb_mst_bridge #(
        .TIMEOUT_CYC(4),
        .ADDR_BASE  (BASE)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n_i),
        .wr_in   (wr_in),
        .rd_in   (rd_in),
        .addr_in (addr_in),
        .data_in (data_in),
        .data_out(data_out),
        .busy    (busy),
        .done    (done),
        .err_out (err_out),
        .drop_out(drop_out),
        .wb      (wb)
    );

    always #5 clk = ~clk;

    // resp: 0 ack, 1 err, 2 none (timeout), 3 ack+err
    typedef struct {
        logic        wr;
        logic        rd;
        logic [7:0]  addr;
        logic [31:0] wdat;
        int          dly;
        int          resp;
        logic [31:0] rdat;
        int          ecyc;
        logic        eerr;
        logic [31:0] edout;
        logic        ewe;
        logic [31:0] eadr;
        logic [31:0] edat;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic run(input vec_t v);
        int cc;
        bit seen;
        @(negedge clk);
        wr_in = v.wr; rd_in = v.rd;
        addr_in = v.addr; data_in = v.wdat;
        @(posedge clk);
        #1 wr_in = 1'b0; rd_in = 1'b0;
        @(negedge clk);
        chk("cyc_start", {31'b0, wb.cyc_o}, 1);
        chk("stb_start", {31'b0, wb.stb_o}, 1);
        chk("busy_start", {31'b0, busy}, 1);
        chk("we", {31'b0, wb.we_o}, {31'b0, v.ewe});
        chk("adr", wb.adr_o, v.eadr);
        chk("sel", {28'b0, wb.sel_o}, 32'hF);
        chk("dat_o", wb.dat_o, v.edat);
        cc = 0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) begin
                seen = 1;
                break;
            end
            if (wb.cyc_o) cc++;
            if (k == v.dly && v.resp != 2) begin
                wb.ack_i = (v.resp == 0 || v.resp == 3);
                wb.err_i = (v.resp == 1 || v.resp == 3);
                wb.dat_i = v.rdat;
            end
            @(posedge clk);
            #1 wb.ack_i = 1'b0; wb.err_i = 1'b0;
            wb.dat_i = '0;
            @(negedge clk);
        end
        chk("done_seen", {31'b0, seen}, 1);
        if (seen) begin
            chk("cyc_cycles", cc, v.ecyc);
            chk("err_out", {31'b0, err_out}, {31'b0, v.eerr});
            chk("data_out", data_out, v.edout);
            chk("cyc_end", {31'b0, wb.cyc_o}, 0);
            chk("busy_end", {31'b0, busy}, 0);
            chk("adr_end", wb.adr_o, 0);
            chk("sel_end", {28'b0, wb.sel_o}, 0);
            @(negedge clk);
            chk("done_1cyc", {31'b0, done}, 0);
            chk("err_1cyc", {31'b0, err_out}, 0);
        end
    endtask

    vec_t tv;
    int   wt;

    initial begin
        wb.ack_i = 1'b0;
        wb.err_i = 1'b0;
        wb.dat_i = '0;

        tbl[0] = '{1, 0, 8'h10, 32'hA5A5_0001, 2, 0, 32'h0,
                   3, 0, 32'h0, 1, BASE | 32'h10, 32'hA5A5_0001};
        tbl[1] = '{0, 1, 8'h24, 32'h1111_1111, 0, 0, 32'hDEAD_BEEF,
                   1, 0, 32'hDEAD_BEEF, 0, BASE | 32'h24, 32'h0};
        tbl[2] = '{0, 1, 8'h30, 32'h0, 0, 2, 32'h0,
                   5, 1, 32'hDEAD_BEEF, 0, BASE | 32'h30, 32'h0};
        tbl[3] = '{0, 1, 8'h08, 32'h0, 1, 1, 32'h9999_9999,
                   2, 1, 32'hDEAD_BEEF, 0, BASE | 32'h08, 32'h0};
        tbl[4] = '{1, 1, 8'h44, 32'h1234_5678, 0, 0, 32'h7777_7777,
                   1, 0, 32'hDEAD_BEEF, 1, BASE | 32'h44, 32'h1234_5678};
        tbl[5] = '{0, 1, 8'hFC, 32'h0, 0, 3, 32'h1111_2222,
                   1, 1, 32'hDEAD_BEEF, 0, BASE | 32'hFC, 32'h0};
        tbl[6] = '{0, 1, 8'h04, 32'h0, 3, 0, 32'hCAFE_F00D,
                   4, 0, 32'hCAFE_F00D, 0, BASE | 32'h04, 32'h0};
        tbl[7] = '{1, 0, 8'hFF, 32'h0000_00AB, 4, 0, 32'h0,
                   5, 0, 32'hCAFE_F00D, 1, BASE | 32'hFF, 32'hAB};

        #12;
        chk("rst_cyc", {31'b0, wb.cyc_o}, 0);
        chk("rst_stb", {31'b0, wb.stb_o}, 0);
        chk("rst_adr", wb.adr_o, 0);
        chk("rst_dat", wb.dat_o, 0);
        chk("rst_dout", data_out, 0);
        chk("rst_flags", {28'b0, busy, done, err_out, drop_out}, 0);
        @(negedge clk);
        rst_n_i = 1'b1;

        for (int i = 0; i < 8; i++) run(tbl[i]);

        // strobe while busy, then again on the ack edge
        @(negedge clk);
        wr_in = 1'b1; addr_in = 8'h10; data_in = 32'h0000_0001;
        @(posedge clk);
        #1 wr_in = 1'b0;
        @(negedge clk);
        wr_in = 1'b1; addr_in = 8'h20; data_in = 32'h0000_0002;
        @(posedge clk);
        #1 wr_in = 1'b0;
        @(negedge clk);
        chk("drop_pulse", {31'b0, drop_out}, 1);
        chk("drop_adr", wb.adr_o, BASE | 32'h10);
        chk("drop_dat", wb.dat_o, 32'h1);
        rd_in = 1'b1; addr_in = 8'h28;
        wb.ack_i = 1'b1;
        @(posedge clk);
        #1 rd_in = 1'b0; wb.ack_i = 1'b0;
        @(negedge clk);
        chk("drop_ack_edge", {31'b0, drop_out}, 1);
        chk("drop_done", {31'b0, done}, 1);
        chk("drop_noerr", {31'b0, err_out}, 0);
        chk("drop_idle", {31'b0, wb.cyc_o}, 0);
        chk("drop_dout", data_out, 32'hCAFE_F00D);
        @(negedge clk);
        chk("drop_clear", {31'b0, drop_out}, 0);

        // back-to-back: new strobe in the done cycle
        wr_in = 1'b1; addr_in = 8'h50; data_in = 32'h5;
        @(posedge clk);
        #1 wr_in = 1'b0;
        @(negedge clk);
        wb.ack_i = 1'b1;
        @(posedge clk);
        #1 wb.ack_i = 1'b0;
        @(negedge clk);
        chk("b2b_done1", {31'b0, done}, 1);
        rd_in = 1'b1; addr_in = 8'h54;
        @(posedge clk);
        #1 rd_in = 1'b0;
        @(negedge clk);
        chk("b2b_cyc", {31'b0, wb.cyc_o}, 1);
        chk("b2b_we", {31'b0, wb.we_o}, 0);
        chk("b2b_adr", wb.adr_o, BASE | 32'h54);
        chk("b2b_nodrop", {31'b0, drop_out}, 0);
        wb.ack_i = 1'b1; wb.dat_i = 32'h55AA_55AA;
        @(posedge clk);
        #1 wb.ack_i = 1'b0; wb.dat_i = '0;
        @(negedge clk);
        chk("b2b_done2", {31'b0, done}, 1);
        chk("b2b_dout", data_out, 32'h55AA_55AA);

        // async reset mid-BUS, then a clean read
        @(negedge clk);
        rd_in = 1'b1; addr_in = 8'h60;
        @(posedge clk);
        #1 rd_in = 1'b0;
        @(negedge clk);
        chk("pre_rst_cyc", {31'b0, wb.cyc_o}, 1);
        #2 rst_n_i = 1'b0;
        #1;
        chk("rst_mid_cyc", {31'b0, wb.cyc_o}, 0);
        chk("rst_mid_stb", {31'b0, wb.stb_o}, 0);
        chk("rst_mid_dout", data_out, 0);
        wt = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) wt++;
        end
        chk("rst_no_done", wt, 0);
        rst_n_i = 1'b1;
        tv = '{0, 1, 8'h64, 32'h0, 1, 0, 32'h0BAD_F00D,
               2, 0, 32'h0BAD_F00D, 0, BASE | 32'h64, 32'h0};
        run(tv);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
